sorcerer_ram_upload: RTL and testbench

//  Read-side counterpart to the ROM/PAC/tape download path: services hps_io upload

---
 rtl/sorcerer_ram_upload_if.sv | 27 ++
 rtl/sorcerer_ram_upload.sv | 126 ++++++++++++
 tb/tb_sorcerer_ram_upload.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sorcerer_ram_upload_if.sv
// Bundles the hps_io upload handshake and the Sorcerer RAM read port.
// The slave modport is the upload engine; the master modport is the hps_io/RAM side.
interface sorcerer_ram_upload_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic              ioctl_upload;
  logic              ioctl_rd;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] ram_top;
  logic              cpu_mem_busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_din;
  logic [7:0]        upl_chk;

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, ram_top, cpu_mem_busy, mem_din,
    output ioctl_din, ioctl_wait, mem_addr, mem_rd, upl_chk
  );

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, ram_top, cpu_mem_busy, mem_din,
    input  ioctl_din, ioctl_wait, mem_addr, mem_rd, upl_chk
  );
endinterface

// File: rtl/sorcerer_ram_upload.sv
// Services hps_io upload reads from Sorcerer main RAM, yielding to the CPU on contention.
// Optional running byte checksum on upl_chk when UPLOAD_CHECKSUM_EN is defined.
module sorcerer_ram_upload #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned MEM_LAT = 2
) (
  input logic                   clk_sys,
  input logic                   reset,
  sorcerer_ram_upload_if.slave  bus
);
  localparam int unsigned CntW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {StIdle, StArb, StRead, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic              mem_rd_q, mem_rd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    din_d      = din_q;
    wait_d     = wait_q;
    mem_rd_d   = 1'b0;
    cnt_d      = cnt_q;

    if (state_q == StIdle) begin
      if (bus.ioctl_rd && bus.ioctl_upload) begin
        addr_d = bus.ioctl_addr;
        wait_d = 1'b1;
        if (bus.ioctl_addr > bus.ram_top) begin
          din_d   = 8'hFF;
          state_d = StDone;
        end else begin
          state_d = StArb;
        end
      end
    end else if (!bus.ioctl_upload) begin
      // Session dropped mid-request: return to idle without touching ioctl_din.
      state_d = StIdle;
      wait_d  = 1'b0;
    end else begin
      unique case (state_q)
        StArb: begin
          if (!bus.cpu_mem_busy) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = addr_q;
            cnt_d      = CntW'(MEM_LAT);
            state_d    = StRead;
          end
        end
        StRead: begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            din_d   = bus.mem_din;
            state_d = StDone;
          end
        end
        StDone: begin
          wait_d  = 1'b0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      mem_addr_q <= '0;
      din_q      <= 8'h00;
      wait_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      din_q      <= din_d;
      wait_q     <= wait_d;
      mem_rd_q   <= mem_rd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_rd     = mem_rd_q;

`ifdef UPLOAD_CHECKSUM_EN
  logic       upload_q;
  logic [7:0] chk_q, chk_d;

  // DONE with upload still high is a completed request; din_q already holds its byte.
  always_comb begin
    chk_d = chk_q;
    if (bus.ioctl_upload && !upload_q) begin
      chk_d = 8'h00;
    end else if (state_q == StDone && bus.ioctl_upload) begin
      chk_d = chk_q + din_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      upload_q <= 1'b0;
      chk_q    <= 8'h00;
    end else begin
      upload_q <= bus.ioctl_upload;
      chk_q    <= chk_d;
    end
  end

  assign bus.upl_chk = chk_q;
`else
  assign bus.upl_chk = 8'h00;
`endif
endmodule

// File: tb/tb_sorcerer_ram_upload.sv
// Randomized self-checking bench for sorcerer_ram_upload against a transaction-level model.
module tb_sorcerer_ram_upload;
  localparam int unsigned AddrW  = 16;
  localparam int          MemLat = 2;
`ifdef UPLOAD_CHECKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  sorcerer_ram_upload_if #(.ADDR_W(AddrW)) bus ();

  sorcerer_ram_upload #(
    .ADDR_W (AddrW),
    .MEM_LAT(MemLat)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  logic [7:0] mem [65536];
  assign bus.mem_din = mem[bus.mem_addr];

  int errors = 0;
  int checks = 0;

  logic [7:0]       exp_din;
  logic [7:0]       exp_chk;
  logic [AddrW-1:0] exp_mem_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Begin a fresh upload session; the checksum restarts from zero.
  task automatic new_session();
    @(negedge clk_sys);
    bus.ioctl_upload = 1'b0;
    @(negedge clk_sys);
    bus.ioctl_upload = 1'b1;
    exp_chk = 8'h00;
    @(negedge clk_sys);
    check_eq("chk_session", 32'(bus.upl_chk), 32'(exp_chk));
  endtask

  // One request issued in cycle 0; CPU holds RAM for nbusy cycles from cycle 1;
  // abort_at != 0 drops ioctl_upload during that cycle.
  task automatic do_read(input logic [AddrW-1:0] addr, input int nbusy, input int abort_at);
    bit               in_range, issues;
    int               rd_cnt, rd_cyc, fall_cyc, exp_fall, exp_rd_cyc;
    logic [AddrW-1:0] rd_addr;
    logic [7:0]       exp_val;
    in_range   = (addr <= bus.ram_top);
    issues     = in_range && (abort_at == 0 || abort_at > nbusy + 1);
    exp_rd_cyc = issues ? nbusy + 2 : -1;
    if (abort_at != 0)  exp_fall = abort_at + 1;
    else if (in_range)  exp_fall = 3 + MemLat + nbusy;
    else                exp_fall = 2;
    exp_val  = in_range ? mem[addr] : 8'hFF;
    rd_cnt   = 0;
    rd_cyc   = -1;
    fall_cyc = -1;
    rd_addr  = '0;

    @(negedge clk_sys);
    bus.ioctl_rd     = 1'b1;
    bus.ioctl_addr   = addr;
    bus.cpu_mem_busy = 1'b0;
    for (int c = 1; c <= 40 && fall_cyc < 0; c++) begin
      @(negedge clk_sys);
      if (bus.mem_rd) begin
        rd_cnt++;
        rd_cyc  = c;
        rd_addr = bus.mem_addr;
      end
      if (!bus.ioctl_wait) begin
        fall_cyc         = c;
        bus.ioctl_rd     = 1'b0;
        bus.cpu_mem_busy = 1'b0;
      end else begin
        // Requests while busy must be ignored.
        bus.ioctl_rd   = 1'($urandom_range(0, 1));
        bus.ioctl_addr = AddrW'($urandom);
        if (rd_cnt > 0) bus.cpu_mem_busy = 1'($urandom_range(0, 1));
        else            bus.cpu_mem_busy = (c <= nbusy);
        if (c == abort_at) bus.ioctl_upload = 1'b0;
      end
    end
    bus.ioctl_rd = 1'b0;

    if (issues) exp_mem_addr = addr;
    if (abort_at == 0) begin
      exp_din = exp_val;
      if (ChkEn) exp_chk = exp_chk + exp_val;
    end
    check_eq("wait_fall_cyc", 32'(fall_cyc), 32'(exp_fall));
    check_eq("mem_rd_count", 32'(rd_cnt), 32'(issues ? 1 : 0));
    check_eq("mem_rd_cyc", 32'(rd_cyc), 32'(exp_rd_cyc));
    if (issues) check_eq("mem_rd_addr", 32'(rd_addr), 32'(addr));
    check_eq("mem_addr_hold", 32'(bus.mem_addr), 32'(exp_mem_addr));
    check_eq("ioctl_din", 32'(bus.ioctl_din), 32'(exp_din));
    check_eq("upl_chk", 32'(bus.upl_chk), 32'(exp_chk));
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = '0;
    bus.ram_top      = 16'h7FFF;
    bus.cpu_mem_busy = 1'b0;
    exp_din      = 8'h00;
    exp_chk      = 8'h00;
    exp_mem_addr = '0;

    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check_eq("rst_din", 32'(bus.ioctl_din), 32'h0);
    check_eq("rst_wait", 32'(bus.ioctl_wait), 32'h0);
    check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check_eq("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
    check_eq("rst_chk", 32'(bus.upl_chk), 32'h0);

    // Read request without an upload session is ignored.
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = 16'h0100;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_sys);
      bus.ioctl_rd = 1'b0;
      if (bus.ioctl_wait || bus.mem_rd) seen = 1'b1;
    end
    check_eq("rd_no_upload", 32'(seen), 32'h0);

    new_session();
    mem[16'h0100] = 8'h3C;
    do_read(16'h0100, 0, 0);          // plain read
    do_read(16'h0100, 3, 0);          // CPU contention
    do_read(16'h8000, 0, 0);          // above ram_top
    do_read(16'h7FFF, 0, 0);          // exactly ram_top
    do_read(16'h0200, 0, 3);          // abort in READ
    new_session();
    do_read(16'h0100, 0, 0);
    do_read(16'h0300, 3, 2);          // abort in ARB, no strobe
    new_session();

    // Reset in cycle 1 while arbitrating.
    @(negedge clk_sys);
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = 16'h0300;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    check_eq("pre_rst_wait", 32'(bus.ioctl_wait), 32'h1);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    exp_din      = 8'h00;
    exp_chk      = 8'h00;
    exp_mem_addr = '0;
    check_eq("mid_rst_din", 32'(bus.ioctl_din), 32'h0);
    check_eq("mid_rst_wait", 32'(bus.ioctl_wait), 32'h0);
    check_eq("mid_rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check_eq("mid_rst_chk", 32'(bus.upl_chk), 32'h0);
    seen = bus.mem_rd;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_sys);
      if (bus.mem_rd || bus.ioctl_wait) seen = 1'b1;
    end
    check_eq("mid_rst_no_rd", 32'(seen), 32'h0);

    // Checksum session: 0x80 + 0x90 + 0x10 wraps to 0x20.
    new_session();
    mem[16'h0010] = 8'h80;
    mem[16'h0011] = 8'h90;
    mem[16'h0012] = 8'h10;
    do_read(16'h0010, 0, 0);
    do_read(16'h0011, 1, 0);
    do_read(16'h0012, 0, 0);
    check_eq("chk_sum3", 32'(bus.upl_chk), ChkEn ? 32'h20 : 32'h00);
    new_session();

    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 0) begin
        @(negedge clk_sys);
        case ($urandom_range(0, 2))
          0:       bus.ram_top = 16'h3FFF;
          1:       bus.ram_top = 16'h7FFF;
          default: bus.ram_top = 16'hFFFF;
        endcase
      end
      do_read(AddrW'($urandom), $urandom_range(0, 5), 0);
    end
    bus.ram_top = 16'h3FFF;
    do_read(16'h4000, 2, 0);
    do_read(16'h3FFF, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
